// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a per-register pending (scoreboard) bit.
// Latency: reads are combinational, with same-cycle write bypass; writes and pending updates land at the next rising edge.
// Backpressure: none on the ports; stall is asserted while any read port addresses a pending register.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic                       wr0_en,
    input  logic [AW-1:0]              wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [AW-1:0]              wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       pend_set_en,
    input  logic [AW-1:0]              pend_set_addr,
    output logic                       stall
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;

    logic w_wr0_ok;
    logic w_wr1_ok;
    logic w_set_ok;

    // An address is usable if it exists and is not the hardwired zero register.
    function automatic logic f_valid(input logic [AW-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Reset suppresses writes so the read bypass cannot expose data that reset discards.
    assign w_wr0_ok = !rst && wr0_en      && f_valid(wr0_addr);
    assign w_wr1_ok = !rst && wr1_en      && f_valid(wr1_addr);
    assign w_set_ok = !rst && pend_set_en && f_valid(pend_set_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr1_ok && (wr1_addr == AW'(i))) begin
                    r_regs[i] <= wr1_data;
                end else if (w_wr0_ok && (wr0_addr == AW'(i))) begin
                    r_regs[i] <= wr0_data;
                end
                // A new producer issued this cycle outranks the completing write.
                if (w_set_ok && (pend_set_addr == AW'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if ((w_wr0_ok && (wr0_addr == AW'(i))) ||
                             (w_wr1_ok && (wr1_addr == AW'(i)))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] w_a;
        logic          w_ok;
        logic          w_hit0;
        logic          w_hit1;

        assign w_a    = rd_addr[p*AW +: AW];
        assign w_ok   = !rst && f_valid(w_a);
        assign w_hit0 = w_wr0_ok && (wr0_addr == w_a);
        assign w_hit1 = w_wr1_ok && (wr1_addr == w_a);

        assign rd_data[p*DATA_W +: DATA_W] = !w_ok  ? '0       :
                                             w_hit1 ? wr1_data :
                                             w_hit0 ? wr0_data :
                                                      r_regs[w_a];
        assign rd_pending[p] = w_ok && r_pend[w_a] && !w_hit0 && !w_hit1;
    end

    assign stall = |rd_pending;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default build plus a NUM_REGS=20 build sharing one stimulus stream.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pending;
    logic        stall;
    logic [63:0] rd_data20;
    logic [1:0]  rd_pending20;
    logic        stall20;
    logic        wr0_en, wr1_en, pend_set_en;
    logic [4:0]  wr0_addr, wr1_addr, pend_set_addr;
    logic [31:0] wr0_data, wr1_data;

    int n_chk;
    int n_fail;

    typedef struct {
        string       name;
        int          dut;
        int          port;
        logic [31:0] data;
        logic        pend;
    } exp_t;

    exp_t sb[$];

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .pend_set_en(pend_set_en),
        .pend_set_addr(pend_set_addr), .stall(stall)
    );

    regfile_mp #(.NUM_REGS(20)) u_dut20 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data20),
        .rd_pending(rd_pending20), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .pend_set_en(pend_set_en),
        .pend_set_addr(pend_set_addr), .stall(stall20)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        pend_set_en = 1'b0; pend_set_addr = '0;
    endtask

    function automatic logic [31:0] fill_val(input int r);
        return 32'h0101_0101 * r + 32'hA5;
    endfunction

    task automatic test_reset();
        exp_t e;
        logic [31:0] od;
        logic op;
        rst = 1'b1;
        idle();
        rd_addr = {5'd6, 5'd5};
        @(posedge clk); #1;
        @(posedge clk); #1;
        sb.push_back('{"rst_p0", 0, 0, 32'h0, 1'b0});
        sb.push_back('{"rst_p1", 0, 1, 32'h0, 1'b0});
        sb.push_back('{"rst_stall", 0, -1, 32'h0, 1'b0});
        sb.push_back('{"rst_stall20", 1, -1, 32'h0, 1'b0});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port < 0) begin
                od = 32'h0; op = (e.dut == 0) ? stall : stall20;
            end else begin
                od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
            end
            n_chk++;
            if (od !== e.data || op !== e.pend) begin
                n_fail++;
                $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            idle();
            rd_addr = {5'd6, 5'd5};
            if (c == 0) begin
                wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
            end else begin
                sb.push_back('{"wr_rd_p0", 0, 0, 32'hDEADBEEF, 1'b0});
                sb.push_back('{"wr_rd_p1", 0, 1, 32'h0, 1'b0});
                sb.push_back('{"wr_rd_stall", 0, -1, 32'h0, 1'b0});
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    task automatic test_same_addr();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            idle();
            if (c == 0) begin
                wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
                wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
                rd_addr = {5'd7, 5'd7};
                sb.push_back('{"dual_bypass_p0", 0, 0, 32'h22, 1'b0});
                sb.push_back('{"dual_bypass_p1", 0, 1, 32'h22, 1'b0});
            end else begin
                rd_addr = {5'd5, 5'd7};
                sb.push_back('{"dual_stored", 0, 0, 32'h22, 1'b0});
                sb.push_back('{"dual_other", 0, 1, 32'hDEADBEEF, 1'b0});
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            idle();
            rd_addr = {5'd0, 5'd0};
            if (c == 0) begin
                wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
                pend_set_en = 1'b1; pend_set_addr = 5'd0;
            end
            sb.push_back('{"zero_p0", 0, 0, 32'h0, 1'b0});
            sb.push_back('{"zero_p1", 0, 1, 32'h0, 1'b0});
            sb.push_back('{"zero_stall", 0, -1, 32'h0, 1'b0});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    task automatic test_pending();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            idle();
            rd_addr = {5'd6, 5'd3};
            case (c)
                0: begin
                    pend_set_en = 1'b1; pend_set_addr = 5'd3;
                    sb.push_back('{"pend_set_cycle", 0, 0, 32'h0, 1'b0});
                    sb.push_back('{"pend_set_stall", 0, -1, 32'h0, 1'b0});
                end
                1: begin
                    sb.push_back('{"pend_seen", 0, 0, 32'h0, 1'b1});
                    sb.push_back('{"pend_other", 0, 1, 32'h0, 1'b0});
                    sb.push_back('{"pend_stall", 0, -1, 32'h0, 1'b1});
                end
                2: begin
                    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h55;
                    sb.push_back('{"pend_bypass", 0, 0, 32'h55, 1'b0});
                    sb.push_back('{"pend_bypass_stall", 0, -1, 32'h0, 1'b0});
                end
                default: begin
                    sb.push_back('{"pend_cleared", 0, 0, 32'h55, 1'b0});
                    sb.push_back('{"pend_cleared_stall", 0, -1, 32'h0, 1'b0});
                end
            endcase
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    task automatic test_set_and_write();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            idle();
            rd_addr = {5'd9, 5'd9};
            if (c == 0) begin
                pend_set_en = 1'b1; pend_set_addr = 5'd9;
                wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hAA;
                sb.push_back('{"setwr_bypass", 0, 0, 32'hAA, 1'b0});
            end else begin
                sb.push_back('{"setwr_p0", 0, 0, 32'hAA, 1'b1});
                sb.push_back('{"setwr_p1", 0, 1, 32'hAA, 1'b1});
                sb.push_back('{"setwr_stall", 0, -1, 32'h0, 1'b1});
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            idle();
            rd_addr = {5'd12, 5'd4};
            if (c < 4) begin
                wr0_en = 1'b1; wr0_addr = 5'd4;  wr0_data = 32'd100 + 32'(c);
                wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'd200 + 32'(c);
            end
            sb.push_back('{"b2b_p0", 0, 0, 32'd100 + 32'((c < 4) ? c : 3), 1'b0});
            sb.push_back('{"b2b_p1", 0, 1, 32'd200 + 32'((c < 4) ? c : 3), 1'b0});
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            idle();
            rd_addr = {5'd25, 5'd19};
            if (c == 0) begin
                wr0_en = 1'b1; wr0_addr = 5'd25; wr0_data = 32'h77;
                wr1_en = 1'b1; wr1_addr = 5'd19; wr1_data = 32'h1234;
                pend_set_en = 1'b1; pend_set_addr = 5'd25;
                sb.push_back('{"oor20_bypass19", 1, 0, 32'h1234, 1'b0});
                sb.push_back('{"oor20_bypass25", 1, 1, 32'h0, 1'b0});
                sb.push_back('{"oor32_bypass25", 0, 1, 32'h77, 1'b0});
            end else begin
                sb.push_back('{"oor20_rd19", 1, 0, 32'h1234, 1'b0});
                sb.push_back('{"oor20_rd25", 1, 1, 32'h0, 1'b0});
                sb.push_back('{"oor20_stall", 1, -1, 32'h0, 1'b0});
                sb.push_back('{"oor32_rd25", 0, 1, 32'h77, 1'b1});
                sb.push_back('{"oor32_stall", 0, -1, 32'h0, 1'b1});
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] od;
        logic op;
        for (int r = 1; r < 32; r += 2) begin
            @(posedge clk); #1;
            idle();
            wr0_en = 1'b1; wr0_addr = 5'(r); wr0_data = fill_val(r);
            if (r + 1 < 32) begin
                wr1_en = 1'b1; wr1_addr = 5'(r + 1); wr1_data = fill_val(r + 1);
            end
            if (r == 3 || r == 11 || r == 17 || r == 29) begin
                pend_set_en = 1'b1; pend_set_addr = 5'(r);
            end
        end
        // Pre-reset reads prove the fill took; then one reset cycle with a write and a set in flight.
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            idle();
            rst = 1'b0;
            if (c == 0) begin
                rd_addr = {5'd11, 5'd31};
                sb.push_back('{"fill_r31", 0, 0, fill_val(31), 1'b0});
                sb.push_back('{"fill_r11", 0, 1, fill_val(11), 1'b1});
                sb.push_back('{"fill_stall", 0, -1, 32'h0, 1'b1});
            end else if (c == 1) begin
                rst = 1'b1;
                wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hFFFF;
                pend_set_en = 1'b1; pend_set_addr = 5'd12;
            end else begin
                rd_addr = {5'(2*(c-2) + 1), 5'(2*(c-2))};
                sb.push_back('{"post_rst_p0", 0, 0, 32'h0, 1'b0});
                sb.push_back('{"post_rst_p1", 0, 1, 32'h0, 1'b0});
                sb.push_back('{"post_rst_stall", 0, -1, 32'h0, 1'b0});
                sb.push_back('{"post_rst_stall20", 1, -1, 32'h0, 1'b0});
            end
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.port < 0) begin
                    od = 32'h0; op = (e.dut == 0) ? stall : stall20;
                end else begin
                    od = (e.dut == 0) ? rd_data[e.port*32 +: 32] : rd_data20[e.port*32 +: 32];
                    op = (e.dut == 0) ? rd_pending[e.port] : rd_pending20[e.port];
                end
                n_chk++;
                if (od !== e.data || op !== e.pend) begin
                    n_fail++;
                    $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b", e.name, od, op, e.data, e.pend);
                end
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        rd_addr = '0;
        idle();
        test_reset();
        test_write_read();
        test_same_addr();
        test_zero_reg();
        test_pending();
        test_set_and_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
